sum_accumulator: RTL
====================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter SUM_W, default 9: width of the incoming adder sum (matches the 8-bit adder's 9-bit sum).
REQ-002 Parameter ACC_W, default 16: accumulator width; ACC_W SHALL be greater than SUM_W.
REQ-003 Parameter N_SAMPLES, default 4: sums accepted per accumulation run; legal range 1..255.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request a new accumulation run; sampled only in IDLE.
REQ-007 sum  input  SUM_W  unsigned operand from the upstream adder.
REQ-008 sum_valid  input  1  sum is valid this cycle.
REQ-009 sum_ready  output  1  block accepts sum this cycle.
REQ-010 acc  output  ACC_W  running/final accumulated value.
REQ-011 done  output  1  single-cycle pulse: run complete, acc final.
REQ-012 overflow  output  1  sticky saturation flag for the current run.
REQ-013 busy  output  1  high in ACC and DONE states.

Function
REQ-014 FSM states SHALL be IDLE, ACC and DONE, with only the following transitions.
REQ-015 IDLE: sum_ready=0, done=0; start=1 -> ACC next cycle; same edge clears acc, overflow and sample count to 0.
REQ-016 ACC: sum_ready=1; transfer = sum_valid & sum_ready on a rising edge.
REQ-017 On each transfer: acc <= acc + zero-extended sum, count <= count+1.
REQ-018 Saturation: if acc + sum exceeds 2^ACC_W-1, then acc <= all ones and overflow <= 1; overflow holds until the next start or reset.
REQ-019 sum_valid=0 in ACC: no state change (gaps allowed, no timeout).
REQ-020 Transfer that makes count == N_SAMPLES -> DONE next cycle; no further sums accepted in that run.
REQ-021 DONE: done=1 for exactly one cycle, sum_ready=0; -> IDLE unconditionally.
REQ-022 acc and overflow SHALL hold their final values in IDLE until the next start.
REQ-023 start while in ACC or DONE SHALL be ignored (no restart, no clear).
REQ-024 Latency: done SHALL assert the cycle after the final transfer; minimum run length is N_SAMPLES+2 cycles from the start-sampling edge to done.
REQ-025 sum_ready SHALL depend on state only, never combinationally on sum_valid.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, acc=0, count=0, overflow=0, done=0, sum_ready=0, busy=0.
REQ-027 Reset asserted mid-run SHALL abandon the run; no done pulse; after release, wait for a new start.
REQ-028 The first state change after rst_n rises SHALL occur on a clk edge with rst_n=1.

Verification
REQ-029 Defaults; start pulse, then sums 1,10,99,255 back-to-back with valid -> acc=365, done one cycle after 4th transfer, overflow=0.
REQ-030 Same sums with sum_valid low for 2 cycles between each -> acc=365, exactly 4 transfers, done once, busy high throughout.
REQ-031 ACC_W=10; sums 510,510,510,3 -> acc=1023 after third transfer, overflow=1, final acc=1023, overflow still 1 in IDLE.
REQ-032 start re-asserted during ACC after 2 sums -> ignored; run completes with 4 sums; next start clears acc and overflow to 0.
REQ-033 rst_n low after 2 transfers (acc=11) -> acc=0, busy=0, no done; post-reset start plus 4 sums of 1 -> acc=4.
REQ-034 sum_valid=1 with sum=200 in IDLE and DONE -> sum_ready=0, acc unchanged.

Source files
------------

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES unsigned sums from an upstream adder into a saturating
// accumulator, with a start/busy/done handshake around each run.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; acc/overflow hold the last run's result
//   ACC   | accepting sums (sum_ready=1) until N_SAMPLES transfers
//   DONE  | one-cycle done pulse, then back to IDLE
module sum_accumulator #(
  parameter int SUM_W     = 9,
  parameter int ACC_W     = 16,
  parameter int N_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] sum,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic [ACC_W-1:0] acc,
  output logic             done,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [ACC_W:0]   sum_total;
  logic             transfer;

  // One extra bit on the adder exposes the carry used for saturation.
  always_comb begin
    sum_total = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum};
    transfer  = sum_valid && sum_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      sum_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ACC;
            acc       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            sum_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ACC: begin
          if (transfer) begin
            if (sum_total[ACC_W]) begin
              acc      <= '1;
              overflow <= 1'b1;
            end else begin
              acc <= sum_total[ACC_W-1:0];
            end
            count <= count + 1'b1;
            if (count == LAST_IDX) begin
              state     <= DONE;
              sum_ready <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          sum_ready <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          sum_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
